updown_cnt_monitor: RTL and testbench

Receive-side checker for the bounded 4-bit up/down counter family (MIN/MAX wrap, stop-start, up/down mode). Samples a counter's output bus each enabled cycle and infers direction. Flags illegal steps, counts wraps and drives a locked/fault status. Sits beside any counter instance in test or safety paths, consuming the same MIN/MAX bounds the counter uses.

---
 rtl/updown_mon_pkg.sv | 33 +++
 rtl/updown_step_classify.sv | 64 ++++++
 rtl/updown_cnt_monitor.sv | 176 +++++++++++++++++
 tb/tb_updown_cnt_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/updown_mon_pkg.sv
// Shared encodings for the up/down counter monitor: FSM states, step classes, direction.
// Optional wrap counter is enabled by defining UPDOWN_MON_WRAP_CNT_EN.
package updown_mon_pkg;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    ACQUIRE   = 3'd1,
    LOCK_UP   = 3'd2,
    LOCK_DOWN = 3'd3,
    FAULT     = 3'd4
  } mon_state_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } step_cls_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Classifier verdict for one sample.
  typedef struct packed {
    step_cls_e cls;
    logic      is_wrap;
  } step_res_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

endpackage

// File: rtl/updown_step_classify.sv
// Combinational step classifier: compares current sample c with previous sample p
// against the [min,max] bounds of a wrapping up/down counter.
module updown_step_classify
  import updown_mon_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] c,
  input  logic [W-1:0] min,
  input  logic [W-1:0] max,
  input  logic         cur_dir,
  input  logic         locked,
  output step_cls_e    cls,
  output logic         is_wrap
);

  logic [W:0] pe, ce;
  logic       in_rng;
  logic       up_step, dn_step, wrap_up, wrap_dn;
  logic       up_m, dn_m;
  step_res_t  res;

  // One extra bit keeps p+1 / c+1 from aliasing at the top of the code space.
  assign pe = {1'b0, p};
  assign ce = {1'b0, c};

  assign in_rng  = (c >= min) && (c <= max);
  assign up_step = (p != max) && (ce == pe + (W+1)'(1));
  assign dn_step = (p != min) && (ce + (W+1)'(1) == pe);
  assign wrap_up = (p == max) && (c == min);
  assign wrap_dn = (p == min) && (c == max);
  assign up_m    = up_step | wrap_up;
  assign dn_m    = dn_step | wrap_dn;

  always_comb begin
    res.cls     = ILLEGAL;
    res.is_wrap = 1'b0;
    if (!in_rng) begin
      res.cls = ILLEGAL;
    end else if (c == p || min == max) begin
      res.cls = HOLD;
    end else if (up_m && dn_m) begin
      // Two-value range: both readings fit, so follow the locked direction.
      if (locked && cur_dir == DIR_DN) begin
        res.cls     = DOWN;
        res.is_wrap = wrap_dn;
      end else begin
        res.cls     = UP;
        res.is_wrap = wrap_up;
      end
    end else if (up_m) begin
      res.cls     = UP;
      res.is_wrap = wrap_up;
    end else if (dn_m) begin
      res.cls     = DOWN;
      res.is_wrap = wrap_dn;
    end
  end

  assign cls     = res.cls;
  assign is_wrap = res.is_wrap;

endmodule

// File: rtl/updown_cnt_monitor.sv
// Receive-side checker for a bounded up/down counter: infers direction, flags illegal
// steps, counts wraps. Define UPDOWN_MON_WRAP_CNT_EN to build the wrap counter.
module updown_cnt_monitor
  import updown_mon_pkg::*;
#(
  parameter int W         = 4,
  parameter int ERR_LIMIT = 3,
  parameter int WCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  input  logic [W-1:0]      cnt_in,
  input  logic [W-1:0]      min,
  input  logic [W-1:0]      max,
  output logic              dir,
  output logic              locked,
  output logic              fault,
  output logic              stalled,
  output logic              step_err,
  output logic              wrap,
  output logic              dir_chg,
  output logic [WCNT_W-1:0] wrap_count,
  output logic [7:0]        err_count
);

  localparam int CE_W = $clog2(ERR_LIMIT + 1);
  localparam logic [CE_W-1:0] ERR_LAST = CE_W'(ERR_LIMIT - 1);

  mon_state_e      state, state_n;
  logic [W-1:0]    p, p_n;
  logic [CE_W-1:0] consec_err, consec_n;
  logic            dir_n, stalled_n;
  logic            step_err_n, wrap_n, dir_chg_n;
  logic            err_inc, wrap_inc;

  step_cls_e       cls;
  logic            is_wrap;
  logic            st_locked;
  logic            cur_dir;

  assign st_locked = (state == LOCK_UP) || (state == LOCK_DOWN);
  assign cur_dir   = (state == LOCK_UP) ? DIR_UP : (state == LOCK_DOWN) ? DIR_DN : dir;

  updown_step_classify #(.W(W)) u_cls (
    .p       (p),
    .c       (cnt_in),
    .min     (min),
    .max     (max),
    .cur_dir (cur_dir),
    .locked  (st_locked),
    .cls     (cls),
    .is_wrap (is_wrap)
  );

  always_comb begin
    state_n    = state;
    p_n        = p;
    consec_n   = consec_err;
    dir_n      = dir;
    stalled_n  = stalled;
    step_err_n = 1'b0;
    wrap_n     = 1'b0;
    dir_chg_n  = 1'b0;
    err_inc    = 1'b0;
    wrap_inc   = 1'b0;

    if (resync) begin
      // Sample in the same cycle is discarded; counters survive.
      state_n  = SYNC;
      consec_n = '0;
    end else if (en) begin
      p_n = cnt_in;
      unique case (state)
        SYNC: begin
          state_n   = ACQUIRE;
          stalled_n = 1'b0;
        end
        ACQUIRE: begin
          stalled_n = (cnt_in == p);
          unique case (cls)
            HOLD: ;
            UP: begin
              state_n  = LOCK_UP;
              dir_n    = DIR_UP;
              wrap_n   = is_wrap;
              wrap_inc = is_wrap;
            end
            DOWN: begin
              state_n  = LOCK_DOWN;
              dir_n    = DIR_DN;
              wrap_n   = is_wrap;
              wrap_inc = is_wrap;
            end
            ILLEGAL: begin
              step_err_n = 1'b1;
              err_inc    = 1'b1;
            end
            default: ;
          endcase
        end
        LOCK_UP, LOCK_DOWN: begin
          stalled_n = (cnt_in == p);
          unique case (cls)
            HOLD: consec_n = '0;
            UP: begin
              consec_n  = '0;
              state_n   = LOCK_UP;
              dir_n     = DIR_UP;
              dir_chg_n = (state == LOCK_DOWN);
              wrap_n    = is_wrap;
              wrap_inc  = is_wrap;
            end
            DOWN: begin
              consec_n  = '0;
              state_n   = LOCK_DOWN;
              dir_n     = DIR_DN;
              dir_chg_n = (state == LOCK_UP);
              wrap_n    = is_wrap;
              wrap_inc  = is_wrap;
            end
            ILLEGAL: begin
              step_err_n = 1'b1;
              err_inc    = 1'b1;
              consec_n   = consec_err + CE_W'(1);
              if (consec_err >= ERR_LAST) state_n = FAULT;
            end
            default: ;
          endcase
        end
        FAULT: ;
        default: state_n = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      p          <= '0;
      consec_err <= '0;
      dir        <= DIR_UP;
      stalled    <= 1'b0;
      step_err   <= 1'b0;
      wrap       <= 1'b0;
      dir_chg    <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      p          <= p_n;
      consec_err <= consec_n;
      dir        <= dir_n;
      stalled    <= stalled_n;
      step_err   <= step_err_n;
      wrap       <= wrap_n;
      dir_chg    <= dir_chg_n;
      err_count  <= sat_inc8(err_count, err_inc);
    end
  end

  assign locked = st_locked;
  assign fault  = (state == FAULT);

`ifdef UPDOWN_MON_WRAP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                               wrap_count <= '0;
    else if (wrap_inc && wrap_count != '1) wrap_count <= wrap_count + WCNT_W'(1);
  end
`else
  assign wrap_count = '0;
  logic unused_wrap_inc;
  assign unused_wrap_inc = wrap_inc;
`endif

endmodule

// File: tb/tb_updown_cnt_monitor.sv
// Directed test-plan scenarios plus randomized traffic, checked against a behavioural
// model built from the next-value rules of a wrapping [min,max] counter.
module tb_updown_cnt_monitor;

`ifdef UPDOWN_MON_WRAP_CNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif
  localparam int ERR_LIMIT = 3;

  logic       clk = 1'b0;
  logic       rst, en, resync;
  logic [3:0] cnt_in, min, max;
  logic       dir, locked, fault, stalled, step_err, wrap, dir_chg;
  logic [7:0] wrap_count, err_count;

  updown_cnt_monitor #(.W(4), .ERR_LIMIT(ERR_LIMIT), .WCNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .cnt_in(cnt_in),
    .min(min), .max(max), .dir(dir), .locked(locked), .fault(fault),
    .stalled(stalled), .step_err(step_err), .wrap(wrap), .dir_chg(dir_chg),
    .wrap_count(wrap_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: observable behaviour only.
  bit m_synced, m_locked, m_fault, m_dir, m_stalled;
  bit m_step_err, m_wrap, m_dir_chg;
  int m_p, m_consec, m_errc, m_wrapc;

  function automatic int nxt_up(int p, int mn, int mx);
    return (p == mx) ? mn : p + 1;
  endfunction
  function automatic int nxt_dn(int p, int mn, int mx);
    return (p == mn) ? mx : p - 1;
  endfunction

  task automatic model_reset();
    m_synced = 0; m_locked = 0; m_fault = 0; m_dir = 1; m_stalled = 0;
    m_step_err = 0; m_wrap = 0; m_dir_chg = 0;
    m_p = 0; m_consec = 0; m_errc = 0; m_wrapc = 0;
  endtask

  task automatic model_edge(input bit r, input bit e, input bit rs, input int c,
                            input int mn, input int mx);
    bit up_ok, dn_ok, go_up;
    m_step_err = 0; m_wrap = 0; m_dir_chg = 0;
    if (r) begin
      model_reset();
    end else if (rs) begin
      m_synced = 0; m_locked = 0; m_fault = 0; m_consec = 0;
    end else if (e) begin
      if (m_fault) begin
        m_p = c;
      end else if (!m_synced) begin
        m_synced = 1; m_stalled = 0; m_p = c;
      end else begin
        m_stalled = (c == m_p);
        up_ok = (c == nxt_up(m_p, mn, mx));
        dn_ok = (c == nxt_dn(m_p, mn, mx));
        if (c < mn || c > mx) begin
          m_step_err = 1;
          if (m_errc < 255) m_errc++;
          if (m_locked) begin
            m_consec++;
            if (m_consec >= ERR_LIMIT) begin m_fault = 1; m_locked = 0; end
          end
        end else if (c == m_p || mn == mx) begin
          m_consec = 0;
        end else if (up_ok || dn_ok) begin
          go_up = (up_ok && dn_ok) ? (m_locked ? m_dir : 1'b1) : up_ok;
          m_consec = 0;
          if (m_locked && go_up != m_dir) m_dir_chg = 1;
          m_locked = 1;
          m_dir = go_up;
          m_wrap = go_up ? (m_p == mx) : (m_p == mn);
          if (m_wrap && WC_EN && m_wrapc < 255) m_wrapc++;
        end else begin
          m_step_err = 1;
          if (m_errc < 255) m_errc++;
          if (m_locked) begin
            m_consec++;
            if (m_consec >= ERR_LIMIT) begin m_fault = 1; m_locked = 0; end
          end
        end
        m_p = c;
      end
    end
  endtask

  task automatic check_all();
    chk("dir",        32'(dir),        32'(m_dir));
    chk("locked",     32'(locked),     32'(m_locked));
    chk("fault",      32'(fault),      32'(m_fault));
    chk("stalled",    32'(stalled),    32'(m_stalled));
    chk("step_err",   32'(step_err),   32'(m_step_err));
    chk("wrap",       32'(wrap),       32'(m_wrap));
    chk("dir_chg",    32'(dir_chg),    32'(m_dir_chg));
    chk("wrap_count", 32'(wrap_count), m_wrapc);
    chk("err_count",  32'(err_count),  m_errc);
  endtask

  task automatic step(input bit r, input bit e, input bit rs, input int c);
    rst = r; en = e; resync = rs; cnt_in = 4'(c);
    @(posedge clk);
    model_edge(r, e, rs, c, int'(min), int'(max));
    #1;
    check_all();
  endtask

  task automatic feed(input int mn, input int mx, input int vals[$]);
    min = 4'(mn); max = 4'(mx);
    foreach (vals[i]) step(0, 1, 0, vals[i]);
  endtask

  int ctr, cdir, mn, mx, roll;

  initial begin
    rst = 1; en = 0; resync = 0; cnt_in = 0; min = 0; max = 15;
    model_reset();
    step(1, 0, 0, 0);
    chk("rst_dir", 32'(dir), 1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_errc", 32'(err_count), 0);

    // Scenario 1: up count with one wrap
    feed(2, 5, '{2, 3});
    chk("s1_locked", 32'(locked), 1);
    chk("s1_dir", 32'(dir), 1);
    feed(2, 5, '{4, 5, 2});
    chk("s1_wrap", 32'(wrap), 1);
    chk("s1_wcnt", 32'(wrap_count), WC_EN ? 1 : 0);
    step(0, 0, 0, 9);
    chk("s1_wrap_idle", 32'(wrap), 0);

    // Scenario 2: down count with a stall
    step(1, 0, 0, 0);
    feed(0, 15, '{7, 6, 6});
    chk("s2_stalled", 32'(stalled), 1);
    feed(0, 15, '{5});
    chk("s2_dir", 32'(dir), 0);
    chk("s2_locked", 32'(locked), 1);
    chk("s2_errc", 32'(err_count), 0);

    // Scenario 3: three illegal steps force FAULT; resync keeps err_count
    step(1, 0, 0, 0);
    feed(2, 5, '{2, 3, 4, 9, 1, 3});
    chk("s3_fault", 32'(fault), 1);
    chk("s3_errc", 32'(err_count), 3);
    step(0, 1, 1, 4);
    chk("s3_resync_fault", 32'(fault), 0);
    chk("s3_resync_errc", 32'(err_count), 3);

    // Scenario 4: two-value range resolves as UP, wrap not reversal
    step(1, 0, 0, 0);
    feed(3, 4, '{3, 4});
    chk("s4_dir", 32'(dir), 1);
    feed(3, 4, '{3});
    chk("s4_wrap", 32'(wrap), 1);
    chk("s4_dirchg", 32'(dir_chg), 0);

    // Scenario 5: reversal, then reset with en high
    step(1, 0, 0, 0);
    feed(0, 15, '{3, 4, 5, 4});
    chk("s5_dirchg", 32'(dir_chg), 1);
    chk("s5_dir", 32'(dir), 0);
    chk("s5_steperr", 32'(step_err), 0);
    step(1, 1, 0, 7);
    chk("s5_rst_dir", 32'(dir), 1);
    chk("s5_rst_locked", 32'(locked), 0);

    // Randomized traffic around a reference counter, with noise and bound changes
    mn = 2; mx = 11; ctr = 5; cdir = 1;
    min = 4'(mn); max = 4'(mx);
    for (int i = 0; i < 3000; i++) begin
      roll = int'($urandom_range(0, 999));
      if (roll < 15) begin
        mn = int'($urandom_range(0, 15)); mx = int'($urandom_range(0, 15));
        if (roll < 12 && mn > mx) begin int t = mn; mn = mx; mx = t; end
        min = 4'(mn); max = 4'(mx);
        if (ctr < mn) ctr = mn;
        if (ctr > mx) ctr = mx;
      end
      roll = int'($urandom_range(0, 99));
      if (roll < 3) cdir = 1 - cdir;
      if (roll < 8)       ctr = int'($urandom_range(0, 15));
      else if (roll < 20) ctr = ctr;
      else                ctr = cdir ? nxt_up(ctr, mn, mx) : nxt_dn(ctr, mn, mx);
      if (ctr < 0 || ctr > 15) ctr = mn;
      roll = int'($urandom_range(0, 999));
      step(roll < 4, $urandom_range(0, 3) != 0, roll >= 4 && roll < 24, ctr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
